// File: rtl/spi_rx_if.sv
// Slave bus bundle for spi_rx: a select/ready access carrying byte strobes, address and data.
// master drives the request side and slave returns ready and data_o.
interface spi_rx_if;
    logic        select;
    logic [3:0]  wstrb;
    logic [3:0]  addr;
    logic [31:0] data_i;
    logic        ready;
    logic [31:0] data_o;

    modport master (output select, wstrb, addr, data_i, input  ready, data_o);
    modport slave  (input  select, wstrb, addr, data_i, output ready, data_o);
endinterface

// File: rtl/spi_rx.sv
// SPI mode-0 receive target: synchronised MOSI bytes are queued in a FIFO read over a 2-cycle slave bus.
// A byte is queued 4 clk after its 8th SCLK edge reaches the pins; no backpressure, a full FIFO drops and flags overrun.
module spi_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic    clk,
    input  logic    reset,
    spi_rx_if.slave bus,
    input  logic    spi_cs,
    input  logic    spi_clk,
    input  logic    spi_mosi,
    output logic    irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // ---------------- input synchronisers and edge detect ----------------
    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sclk_prev_q;
    logic                   cs_s, sclk_s, mosi_s;
    logic                   sclk_rise, cs_rise, cs_fall;

    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // ---------------- state ----------------
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push_vld_q, push_vld_d;
    logic [7:0]    push_dat_q, push_dat_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          en_q, en_d, irq_en_q, irq_en_d;
    logic          ready_q, ready_d;
    logic [31:0]   data_o_q, data_o_d;
    logic          irq_q, irq_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    // ---------------- bus decode ----------------
    logic       acc, is_rd, is_wr, pop, w1c, ctrl_wr, flush;
    logic       not_empty, full, push_ok, ovr_set, frame_set;
    logic [1:0] reg_sel;
    logic [7:0] shift_val;
    logic [31:0] status_w, rdata;
    logic       unused_ok;

    assign unused_ok = ^{bus.addr[1:0], bus.data_i[31:4]};

    // Accesses commit on the edge that raises ready, so a held select never repeats a side effect.
    assign acc     = bus.select & ~ready_q;
    assign is_rd   = acc & (bus.wstrb == 4'b0000);
    assign is_wr   = acc & (bus.wstrb != 4'b0000);
    assign reg_sel = bus.addr[3:2];

    assign not_empty = (count_q != '0);
    assign full      = (count_q == DEPTH_C);
    assign pop       = is_rd & (reg_sel == REG_DATA) & not_empty;
    assign w1c       = is_wr & (reg_sel == REG_STATUS) & bus.wstrb[0];
    assign ctrl_wr   = is_wr & (reg_sel == REG_CTRL) & bus.wstrb[0];
    assign flush     = ctrl_wr & bus.data_i[2];

    assign push_ok = push_vld_q & (~full | pop) & ~flush;
    assign ovr_set = push_vld_q & full & ~pop & ~flush;

    assign en_d     = ctrl_wr ? bus.data_i[0] : en_q;
    assign irq_en_d = ctrl_wr ? bus.data_i[1] : irq_en_q;

    // ---------------- bit deserialiser ----------------
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        push_vld_d = 1'b0;
        push_dat_d = push_dat_q;
        frame_set  = 1'b0;
        shift_val  = MSB_FIRST ? {shreg_q[6:0], mosi_s} : {mosi_s, shreg_q[7:1]};

        if (sclk_rise && !cs_s && en_q) begin
            shreg_d   = shift_val;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                push_vld_d = 1'b1;
                push_dat_d = shift_val;
            end
        end
        if (cs_fall) begin
            bit_cnt_d = 3'd0;
        end
        if (cs_rise && (bit_cnt_q != 3'd0)) begin
            bit_cnt_d = 3'd0;
            frame_set = en_d;
        end
        // Disabling drops the partial byte silently; flush also discards a byte completing now.
        if (!en_d || flush) begin
            bit_cnt_d = 3'd0;
        end
        if (flush) begin
            push_vld_d = 1'b0;
        end
    end

    // ---------------- FIFO bookkeeping and flags ----------------
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end

        // A flag being set in the same cycle as its clear stays set.
        if (w1c && bus.data_i[2]) overrun_d = 1'b0;
        if (ovr_set)              overrun_d = 1'b1;
        if (w1c && bus.data_i[3]) frame_err_d = 1'b0;
        if (frame_set)            frame_err_d = 1'b1;
    end

    // ---------------- read mux and outputs ----------------
    always_comb begin
        status_w = {17'b0, 7'(count_q), 3'b0, ~cs_s, frame_err_q, overrun_q, full, not_empty};
        rdata    = '0;
        case (reg_sel)
            REG_DATA:   rdata = {24'b0, (not_empty ? mem_q[rd_ptr_q] : 8'h00)};
            REG_STATUS: rdata = status_w;
            REG_CTRL:   rdata = {30'b0, irq_en_q, en_q};
            default:    rdata = '0;
        endcase
        data_o_d = is_rd ? rdata : 32'b0;
        ready_d  = bus.select & ~ready_q;
        irq_d    = irq_en_q & (not_empty | overrun_q | frame_err_q);
    end

    assign bus.ready  = ready_q;
    assign bus.data_o = data_o_q;
    assign irq        = irq_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
            push_vld_q  <= 1'b0;
            push_dat_q  <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            ready_q     <= 1'b0;
            data_o_q    <= 32'b0;
            irq_q       <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            push_vld_q  <= push_vld_d;
            push_dat_q  <= push_dat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            ready_q     <= ready_d;
            data_o_q    <= data_o_d;
            irq_q       <= irq_d;
        end
    end
endmodule
